fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the fetch-stage PC and sequences instruction-memory requests through a valid/ready request channel and a valid-only response channel.
- Allows one outstanding request.
- Drives the instruction/PC+4 inputs of the F/D pipeline register, plus a bubble (clear) for it.
- Absorbs decode stalls and branch redirects, including discarding stale responses that arrive after a redirect.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- imem_req_valid  output  1  request-channel valid.
- imem_req_addr  output  32  fetch address (word aligned).
- imem_req_ready  input  1  memory accepts request when valid&ready.
- imem_resp_valid  input  1  one-cycle pulse with read data.
- imem_resp_data  input  32  instruction word.
- stall_d  input  1  hazard-unit decode stall (also drives the F/D register stall).
- redirect_valid  input  1  branch/jump taken in decode (pc_src_d).
- redirect_pc  input  32  redirect target; bits [1:0] are forced to 0.
- pc_f  output  32  current fetch PC.
- pc_plus_four_f  output  32  pc_f+4, modulo 2^32.
- instruction_f  output  32  held instruction word; 0 when not valid.
- bubble_d  output  1  drives the F/D register clear input.
- stall_f  output  1  to the hazard unit: fetch is not delivering this cycle.

Behaviour:
- States: ISSUE, WAIT, HOLD, DRAIN.
- Reset (reset_n=0 at an edge), including mid-operation:
  - state=ISSUE, pc_f=RESET_PC, instruction buffer=0.
  - Instruction memory shares reset_n; any in-flight response is lost.
  - imem_resp_valid seen in ISSUE is always ignored.
- Redirect qualifier: redirect_valid is acted on only when stall_d=0 ("redirect" below means redirect_valid&!stall_d).
  - On redirect, the PC register loads {redirect_pc[31:2],2'b00}.
- ISSUE:
  - imem_req_valid=1, imem_req_addr=pc_f.
  - accept (valid&ready) and no redirect -> WAIT.
  - accept and redirect -> DRAIN; the accepted request is now stale.
  - no accept and redirect -> stay ISSUE. The address changes next cycle; this is the only permitted change of address while valid is held.
  - no accept and no redirect -> stay ISSUE; address held stable.
- WAIT:
  - imem_req_valid=0.
  - resp and no redirect -> capture imem_resp_data into the buffer -> HOLD.
  - resp and redirect in the same cycle -> discard the data -> ISSUE at the new PC.
  - redirect without resp -> DRAIN.
- HOLD:
  - instruction_f=buffer, bubble_d=0.
  - stall_d=1 -> stay HOLD; nothing changes.
  - stall_d=0 and no redirect -> the F/D register latches at this edge; pc_f <= pc_f+4 -> ISSUE.
  - redirect -> bubble_d=1 this cycle (wrong-path instruction squashed); buffer discarded -> ISSUE at the new PC.
- DRAIN:
  - imem_req_valid=0.
  - resp -> discard -> ISSUE.
  - a further redirect overwrites the PC only; the state does not change unless resp arrives.
- bubble_d=1 in ISSUE, WAIT and DRAIN, and in HOLD on redirect.
- stall_f=1 whenever state!=HOLD or stall_d=1.
- Latency: minimum 3 cycles per instruction with zero-wait memory (ISSUE accept -> WAIT resp -> HOLD deliver).
- PC increment wraps: pc_f=32'hFFFF_FFFC -> next 32'h0000_0000.
- instruction_f is 0 in every state except HOLD.
- Outputs after reset:
  - imem_req_valid=1, imem_req_addr=RESET_PC.
  - pc_f=RESET_PC, pc_plus_four_f=RESET_PC+4.
  - instruction_f=0, bubble_d=1, stall_f=1.
- There is never more than one request outstanding. imem_req_valid is never asserted outside ISSUE.

Test Plan:
1. Reset, then zero-wait memory returning addr^32'hA5A5_0000, stall_d=0 -> ISSUE/WAIT/HOLD repeats every 3 cycles. Delivered pc_plus_four_f values are 0x0040_0004, 0x0040_0008, 0x0040_000C, with matching data.
2. imem_req_ready held 0 for 4 cycles -> imem_req_valid=1 and addr=0x0040_0000 stable for all 4 cycles; bubble_d=1 throughout; accept on cycle 5.
3. In HOLD, stall_d=1 for 3 cycles -> instruction_f held, pc_f unchanged, bubble_d=0. Release -> pc_f advances by 4 the cycle after.
4. Redirect to 0x0040_0103 while in WAIT, response 2 cycles later -> DRAIN; stale response discarded; next request addr=0x0040_0100; bubble_d=1 until new data is delivered.
5. Redirect in HOLD with stall_d=0 -> bubble_d=1 that cycle. Redirect with stall_d=1 -> ignored. Redirect coincident with resp in WAIT -> data dropped, next ISSUE at target.
6. reset_n=0 asserted in WAIT, response pulse arrives in the first post-reset cycle -> response ignored; addr=RESET_PC. PC wrap: redirect to 0xFFFF_FFFC then deliver -> next addr 0x0000_0000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the fetch-stage PC and walks instruction-memory requests through a
// valid/ready request channel and a valid-only response channel, with at most
// one request outstanding. The fetched word is held in a local buffer and
// presented to the F/D pipeline register together with PC+4. A bubble (F/D
// clear) is raised whenever no valid instruction is being delivered.
//
// Decode stalls freeze delivery. Branch redirects (acted on only when decode
// is not stalled) reload the PC. A response belonging to a request issued
// before a redirect is stale and is drained without being delivered.
//
// Ports:
//   clock            system clock, rising-edge active
//   reset_n          synchronous active-low reset
//   imem_req_valid   request valid (asserted only in ISSUE)
//   imem_req_addr    word-aligned fetch address (= pc_f)
//   imem_req_ready   memory accepts the request when valid & ready
//   imem_resp_valid  one-cycle pulse accompanying read data
//   imem_resp_data   instruction word
//   stall_d          decode stall from the hazard unit
//   redirect_valid   taken branch/jump in decode
//   redirect_pc      redirect target; low two bits ignored
//   pc_f             current fetch PC
//   pc_plus_four_f   pc_f + 4 (wraps modulo 2^32)
//   instruction_f    held instruction word, 0 when not delivering
//   bubble_d         clear for the F/D register
//   stall_f          fetch is not delivering this cycle
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset_n,

    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,

    input  logic        stall_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic [31:0] pc_f,
    output logic [31:0] pc_plus_four_f,
    output logic [31:0] instruction_f,
    output logic        bubble_d,
    output logic        stall_f
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] instr_q;
    logic [31:0] instr_next;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        req_accept;
    logic [31:0] pc_inc;

    // A redirect issued while decode is stalled belongs to an instruction
    // that has not really resolved yet, so it is ignored.
    assign redirect        = redirect_valid & ~stall_d;
    assign redirect_target = redirect_pc & WORD_MASK;
    assign pc_inc          = pc_q + 32'd4;
    assign req_accept      = imem_req_valid & imem_req_ready;

    // ------------------------------------------------------------------
    // State / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= ISSUE;
            pc_q    <= RESET_PC & WORD_MASK;
            instr_q <= '0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            instr_q <= instr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        pc_next        = pc_q;
        instr_next     = instr_q;
        imem_req_valid = 1'b0;
        bubble_d       = 1'b1;
        instruction_f  = '0;

        unique case (state)
            ISSUE: begin
                // Responses seen here can only be leftovers from before a
                // reset and are ignored. The address may change while valid
                // is held only as a result of a redirect.
                imem_req_valid = 1'b1;
                if (redirect) begin
                    pc_next = redirect_target;
                end
                if (req_accept) begin
                    // An accepted request that coincides with a redirect
                    // fetches the wrong path; its response must be drained.
                    state_next = redirect ? DRAIN : WAIT;
                end
            end

            WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect) begin
                        pc_next    = redirect_target;
                        state_next = ISSUE;
                    end else begin
                        instr_next = imem_resp_data;
                        state_next = HOLD;
                    end
                end else if (redirect) begin
                    pc_next    = redirect_target;
                    state_next = DRAIN;
                end
            end

            HOLD: begin
                instruction_f = instr_q;
                bubble_d      = redirect;
                if (!stall_d) begin
                    // F/D register latches (or is cleared) at this edge, so
                    // the buffer is no longer needed in either case.
                    instr_next = '0;
                    state_next = ISSUE;
                    pc_next    = redirect ? redirect_target : pc_inc;
                end
            end

            DRAIN: begin
                // Later redirects only retarget the PC; leaving DRAIN still
                // requires the stale response to come back first.
                if (redirect) begin
                    pc_next = redirect_target;
                end
                if (imem_resp_valid) begin
                    state_next = ISSUE;
                end
            end

            default: begin
                state_next = ISSUE;
            end
        endcase
    end

    assign imem_req_addr  = pc_q;
    assign pc_f           = pc_q;
    assign pc_plus_four_f = pc_inc;
    assign stall_f        = (state != HOLD) | stall_d;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] XKEY   = 32'hA5A5_0000;

    logic        clock;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_f;
    logic [31:0] pc_plus_four_f;
    logic [31:0] instruction_f;
    logic        bubble_d;
    logic        stall_f;

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_f           (pc_f),
        .pc_plus_four_f (pc_plus_four_f),
        .instruction_f  (instruction_f),
        .bubble_d       (bubble_d),
        .stall_f        (stall_f)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } delivery_t;

    logic [31:0] exp_req[$];
    delivery_t   exp_del[$];

    int checks   = 0;
    int failures = 0;

    // memory model controls (written by stimulus only)
    int          mem_lat;
    logic        inject;
    logic [31:0] inject_data;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic delivery_t mk(input logic [31:0] pc);
        delivery_t d;
        d.pc    = pc;
        d.pc4   = pc + 32'd4;
        d.instr = pc ^ XKEY;
        return d;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_drained(input string name);
        chk({name, "_req_left"}, exp_req.size(), 0);
        chk({name, "_del_left"}, exp_del.size(), 0);
    endtask

    // Instruction memory: answers addr^XKEY mem_lat cycles after the
    // zero-wait slot; loses pending work on reset; can inject a raw pulse.
    initial begin : memory
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pend = 1'b0;
            end else if (imem_req_valid && imem_req_ready) begin
                pend  = 1'b1;
                cnt   = mem_lat;
                paddr = imem_req_addr;
            end
            @(posedge clock);
            #3;
            imem_resp_valid = 1'b0;
            if (inject) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = inject_data;
            end else if (pend) begin
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = paddr ^ XKEY;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: consumes expected requests and deliveries as the DUT shows them.
    initial begin : monitor
        delivery_t d;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected", imem_req_addr, 32'hxxxx_xxxx);
                    end else begin
                        chk("req_addr", imem_req_addr, exp_req.pop_front());
                    end
                end
                if (imem_req_valid) begin
                    chk("bubble_in_issue", {31'd0, bubble_d}, 32'd1);
                end
                if (!stall_f && !bubble_d) begin
                    if (exp_del.size() == 0) begin
                        chk("del_unexpected", instruction_f, 32'hxxxx_xxxx);
                    end else begin
                        d = exp_del.pop_front();
                        chk("del_pc", pc_f, d.pc);
                        chk("del_pc4", pc_plus_four_f, d.pc4);
                        chk("del_instr", instruction_f, d.instr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        stall_d        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_lat        = 0;
        inject         = 1'b0;
        inject_data    = '0;

        repeat (3) step();
        #1;
        chk("rst_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rst_addr", imem_req_addr, RST_PC);
        chk("rst_pc", pc_f, RST_PC);
        chk("rst_pc4", pc_plus_four_f, 32'h0040_0004);
        chk("rst_instr", instruction_f, 32'd0);
        chk("rst_bubble", {31'd0, bubble_d}, 32'd1);
        chk("rst_stall_f", {31'd0, stall_f}, 32'd1);
        reset_n = 1'b1;
        step();

        // Request held back for four cycles: address must stay put.
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("hold_addr", imem_req_addr, RST_PC);
            chk("hold_bubble", {31'd0, bubble_d}, 32'd1);
            step();
        end

        // Zero-wait streaming: three instructions, one every three cycles.
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h0040_0000);
        exp_req.push_back(32'h0040_0004);
        exp_req.push_back(32'h0040_0008);
        exp_del.push_back(mk(32'h0040_0000));
        exp_del.push_back(mk(32'h0040_0004));
        exp_del.push_back(mk(32'h0040_0008));
        repeat (9) step();
        imem_req_ready = 1'b0;
        check_drained("stream");

        // Decode stall while holding an instruction.
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h0040_000C);
        step();
        imem_req_ready = 1'b0;
        step();
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_instr", instruction_f, 32'hA5E5_000C);
            chk("stall_pc", pc_f, 32'h0040_000C);
            chk("stall_bubble", {31'd0, bubble_d}, 32'd0);
            chk("stall_stall_f", {31'd0, stall_f}, 32'd1);
            step();
        end
        stall_d = 1'b0;
        exp_del.push_back(mk(32'h0040_000C));
        step();
        #1;
        chk("stall_release_pc", pc_f, 32'h0040_0010);
        check_drained("stall");

        // Redirect in WAIT, stale response two cycles later, drained.
        imem_req_ready = 1'b1;
        mem_lat = 2;
        exp_req.push_back(32'h0040_0010);
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        #1;
        chk("wait_redir_bubble", {31'd0, bubble_d}, 32'd1);
        chk("wait_redir_valid", {31'd0, imem_req_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        mem_lat = 0;
        #1;
        chk("drain_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("drain_bubble", {31'd0, bubble_d}, 32'd1);
        step();
        #1;
        chk("drain_resp_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("drain_resp_bubble", {31'd0, bubble_d}, 32'd1);
        step();
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h0040_0100);
        exp_del.push_back(mk(32'h0040_0100));
        #1;
        chk("post_drain_addr", imem_req_addr, 32'h0040_0100);
        step();
        imem_req_ready = 1'b0;
        #1;
        chk("post_drain_bubble", {31'd0, bubble_d}, 32'd1);
        step();
        step();
        check_drained("drain");

        // Redirect in HOLD squashes the held instruction.
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h0040_0104);
        step();
        imem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0200;
        #1;
        chk("hold_redir_bubble", {31'd0, bubble_d}, 32'd1);
        chk("hold_redir_instr", instruction_f, 32'hA5E5_0104);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("hold_redir_pc", pc_f, 32'h0040_0200);
        chk("hold_redir_valid", {31'd0, imem_req_valid}, 32'd1);

        // Redirect under decode stall is ignored.
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h0040_0200);
        step();
        imem_req_ready = 1'b0;
        step();
        stall_d        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0300;
        #1;
        chk("stall_redir_bubble", {31'd0, bubble_d}, 32'd0);
        step();
        #1;
        chk("stall_redir_pc", pc_f, 32'h0040_0200);
        chk("stall_redir_bubble2", {31'd0, bubble_d}, 32'd0);
        step();
        stall_d        = 1'b0;
        redirect_valid = 1'b0;
        exp_del.push_back(mk(32'h0040_0200));
        step();
        #1;
        chk("stall_redir_next_pc", pc_f, 32'h0040_0204);

        // Redirect coincident with the response in WAIT.
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h0040_0204);
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0400;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("coinc_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("coinc_addr", imem_req_addr, 32'h0040_0400);
        chk("coinc_instr", instruction_f, 32'd0);
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h0040_0400);
        exp_del.push_back(mk(32'h0040_0400));
        step();
        imem_req_ready = 1'b0;
        step();
        step();
        check_drained("coinc");

        // Reset while in WAIT; a response pulse right after reset is ignored.
        imem_req_ready = 1'b1;
        mem_lat = 5;
        exp_req.push_back(32'h0040_0404);
        step();
        imem_req_ready = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n     = 1'b1;
        mem_lat     = 0;
        inject      = 1'b1;
        inject_data = 32'hDEAD_BEEF;
        #1;
        chk("post_rst_addr", imem_req_addr, RST_PC);
        chk("post_rst_instr", instruction_f, 32'd0);
        step();
        inject = 1'b0;
        #1;
        chk("post_rst_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("post_rst_addr2", imem_req_addr, RST_PC);
        chk("post_rst_instr2", instruction_f, 32'd0);
        chk("post_rst_bubble", {31'd0, bubble_d}, 32'd1);

        // Redirect in ISSUE (unaligned target) then wrap past the top.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus_four_f, 32'h0000_0000);
        imem_req_ready = 1'b1;
        exp_req.push_back(32'hFFFF_FFFC);
        exp_del.push_back(mk(32'hFFFF_FFFC));
        step();
        imem_req_ready = 1'b0;
        step();
        step();
        #1;
        chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
        check_drained("wrap");

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
